gray_rx: RTL and testbench



---
 rtl/gray_rx.sv | 201 ++++++++++++++++++++
 tb/tb_gray_rx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/gray_rx.sv
// -----------------------------------------------------------------------------
// gray_rx -- receive side of the gray counter link.
//
// Samples a WIDTH-bit gray-coded count, decodes it to binary, classifies every
// change against the last accepted value as a legal +1 / -1 step or an illegal
// jump, and keeps a saturating tally of illegal jumps.
//
// Configuration macro:
//   GRAY_SYNC_EN  defined   : gray_in and en pass through a 2-flop synchronizer
//                             before the capture stage (gray_in -> outputs
//                             latency 4 edges). Use when gray_in comes from
//                             another clock domain.
//                 undefined : gray_in feeds the capture stage directly
//                             (latency 2 edges). Same-domain use only.
//
// Parameters: the counter modulus is a power of two, at least 4, and sets
// WIDTH = $clog2 of the modulus; ERR_W is the width of err_cnt.
//
// Ports:
//   clk       in   1      system clock, rising edge
//   rst       in   1      synchronous reset, active-high
//   en        in   1      sample enable; 0 = hold all state, no pulses
//   gray_in   in   WIDTH  gray-coded count from the transmitter
//   bin_out   out  WIDTH  decoded binary of the last accepted sample
//   valid     out  1      1-cycle pulse: legal step accepted
//   dir       out  1      direction of last legal step (1 = up, 0 = down)
//   step_err  out  1      1-cycle pulse: illegal change detected
//   err_cnt   out  ERR_W  saturating count of illegal changes
//   locked    out  1      1 once a first sample has been taken since reset
// -----------------------------------------------------------------------------
module gray_rx #(
  parameter int MOD   = 16,
  parameter int ERR_W = 8,
  localparam int WIDTH = $clog2(MOD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             valid,
  output logic             dir,
  output logic             step_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             locked
);

  localparam logic [WIDTH-1:0] DIFF_UP  = WIDTH'(1);
  localparam logic [WIDTH-1:0] DIFF_DN  = WIDTH'(MOD - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Optional input synchronizer. Gray coding guarantees at most one bit changes
  // per step, so a per-bit 2-flop synchronizer yields either the old or the new
  // code, never a mixture. en is delayed by the same amount so it stays aligned
  // with the sample it qualifies.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] g_src;
  logic             en_src;

`ifdef GRAY_SYNC_EN
  logic [WIDTH-1:0] g_s1, g_s2;
  logic             en_s1, en_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      g_s1  <= '0;
      g_s2  <= '0;
      en_s1 <= 1'b0;
      en_s2 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, so g_s2 takes the old g_s1 and the chain really is two stages.
      g_s1  <= gray_in;
      g_s2  <= g_s1;
      en_s1 <= en;
      en_s2 <= en_s1;
    end
  end

  assign g_src  = g_s2;
  assign en_src = en_s2;
`else
  assign g_src  = gray_in;
  assign en_src = en;
`endif

  // ---------------------------------------------------------------------------
  // Stage 1: capture. g_q only loads on an enabled sample; en_q marks the
  // following cycle as one in which stage 2 may act.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] g_q;
  logic             en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      g_q  <= '0;
      en_q <= 1'b0;
    end else begin
      en_q <= en_src;
      if (en_src) g_q <= g_src;
    end
  end

  // ---------------------------------------------------------------------------
  // Gray -> binary: each binary bit is the XOR of all gray bits at or above it.
  // ---------------------------------------------------------------------------
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] diff;

  assign dec  = gray2bin(g_q);
  // Natural WIDTH-bit wrap makes MOD-1 -> 0 a +1 and 0 -> MOD-1 a -1.
  assign diff = dec - bin_out;

  // ---------------------------------------------------------------------------
  // Stage 2: lock / classify FSM.
  // ---------------------------------------------------------------------------
  state_t           state, state_nxt;
  logic [WIDTH-1:0] bin_nxt;
  logic             valid_nxt;
  logic             dir_nxt;
  logic             step_err_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic             locked_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= UNLOCKED;
      bin_out  <= '0;
      valid    <= 1'b0;
      dir      <= 1'b1;
      step_err <= 1'b0;
      err_cnt  <= '0;
      locked   <= 1'b0;
    end else begin
      state    <= state_nxt;
      bin_out  <= bin_nxt;
      valid    <= valid_nxt;
      dir      <= dir_nxt;
      step_err <= step_err_nxt;
      err_cnt  <= err_nxt;
      locked   <= locked_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    state_nxt    = state;
    bin_nxt      = bin_out;
    valid_nxt    = 1'b0;
    dir_nxt      = dir;
    step_err_nxt = 1'b0;
    err_nxt      = err_cnt;
    locked_nxt   = locked;

    if (en_q) begin
      unique case (state)
        UNLOCKED: begin
          // First sample after reset has no predecessor: adopt it silently.
          bin_nxt    = dec;
          locked_nxt = 1'b1;
          state_nxt  = LOCKED;
        end
        LOCKED: begin
          if (diff == '0) begin
            // Same value re-sampled: nothing to report.
          end else if (diff == DIFF_UP) begin
            bin_nxt   = dec;
            valid_nxt = 1'b1;
            dir_nxt   = 1'b1;
          end else if (diff == DIFF_DN) begin
            bin_nxt   = dec;
            valid_nxt = 1'b1;
            dir_nxt   = 1'b0;
          end else begin
            // Illegal jump: resync to the new value so one glitch produces one
            // error rather than a stream of them.
            bin_nxt      = dec;
            step_err_nxt = 1'b1;
            if (err_cnt != ERR_MAX) err_nxt = err_cnt + 1'b1;
          end
        end
        default: state_nxt = UNLOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_rx.sv
// -----------------------------------------------------------------------------
// tb_gray_rx -- directed self-checking bench for gray_rx.
// Two instances share clk/rst/en/gray_in: dut (ERR_W=8) and dut_s (ERR_W=2,
// used to observe err_cnt saturation). Inputs are driven and outputs sampled
// on the falling edge; latency follows the GRAY_SYNC_EN build.
// -----------------------------------------------------------------------------
module tb_gray_rx;

`ifdef GRAY_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] gray_in;

  logic [3:0] bin_out;
  logic       valid, dir, step_err, locked;
  logic [7:0] err_cnt;

  logic [3:0] bin_out_s;
  logic       valid_s, dir_s, step_err_s, locked_s;
  logic [1:0] err_cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_rx #(.MOD(16), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .gray_in(gray_in),
    .bin_out(bin_out), .valid(valid), .dir(dir), .step_err(step_err),
    .err_cnt(err_cnt), .locked(locked)
  );

  gray_rx #(.MOD(16), .ERR_W(2)) dut_s (
    .clk(clk), .rst(rst), .en(en), .gray_in(gray_in),
    .bin_out(bin_out_s), .valid(valid_s), .dir(dir_s), .step_err(step_err_s),
    .err_cnt(err_cnt_s), .locked(locked_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one enabled sample for a single cycle, then wait until its result
  // is visible on the outputs (falling edge after the LAT-th rising edge).
  task automatic send(input logic [3:0] g);
    gray_in = g;
    en      = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (LAT - 1) @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] b, input logic v,
                            input logic d, input logic se);
    check({tag, ".bin"},  32'(bin_out),  32'(b));
    check({tag, ".val"},  32'(valid),    32'(v));
    check({tag, ".dir"},  32'(dir),      32'(d));
    check({tag, ".serr"}, 32'(step_err), 32'(se));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; gray_in = 4'b0000;

    // 1: reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst.bin",    32'(bin_out),  32'd0);
    check("rst.err",    32'(err_cnt),  32'd0);
    check("rst.locked", 32'(locked),   32'd0);
    check("rst.valid",  32'(valid),    32'd0);
    check("rst.serr",   32'(step_err), 32'd0);
    check("rst.dir",    32'(dir),      32'd1);

    // 2: count up 0,1,2,3
    send(4'b0000);
    check("up.locked", 32'(locked), 32'd1);
    expect_out("up0", 4'd0, 1'b0, 1'b1, 1'b0);
    send(4'b0001); expect_out("up1", 4'd1, 1'b1, 1'b1, 1'b0);
    send(4'b0011); expect_out("up2", 4'd2, 1'b1, 1'b1, 1'b0);
    send(4'b0010); expect_out("up3", 4'd3, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("up.pulse_end", 32'(valid), 32'd0);

    // 3: count down through the wrap, then back up across it
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    send(4'b0001); expect_out("dn.lock", 4'd1, 1'b0, 1'b1, 1'b0);
    send(4'b0000); expect_out("dn0",  4'd0,  1'b1, 1'b0, 1'b0);
    send(4'b1000); expect_out("dn15", 4'd15, 1'b1, 1'b0, 1'b0);
    send(4'b0000); expect_out("wrap.up", 4'd0, 1'b1, 1'b1, 1'b0);

    // 4: illegal jump 3 -> 5, then a repeated sample
    send(4'b0001); send(4'b0011); send(4'b0010);
    expect_out("jmp.pre", 4'd3, 1'b1, 1'b1, 1'b0);
    send(4'b0111);
    expect_out("jmp", 4'd5, 1'b0, 1'b1, 1'b1);
    check("jmp.err", 32'(err_cnt), 32'd1);
    @(negedge clk);
    check("jmp.pulse_end", 32'(step_err), 32'd0);
    send(4'b0111);
    expect_out("same", 4'd5, 1'b0, 1'b1, 1'b0);
    check("same.err", 32'(err_cnt), 32'd1);

    // 5: saturation with ERR_W=2: alternate 0 <-> 8
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    send(4'b0000);
    begin
      logic [3:0] seq [5] = '{4'b1100, 4'b0000, 4'b1100, 4'b0000, 4'b1100};
      logic [1:0] exp_s [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      for (int i = 0; i < 5; i++) begin
        send(seq[i]);
        check($sformatf("sat%0d.err2", i), 32'(err_cnt_s), 32'(exp_s[i]));
        check($sformatf("sat%0d.err8", i), 32'(err_cnt), 32'(i + 1));
        check($sformatf("sat%0d.serr", i), 32'(step_err_s), 32'd1);
      end
    end

    // 6: en low freezes everything while gray_in wanders
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      gray_in = 4'(i * 5 + 1);
      @(negedge clk);
      check($sformatf("frz%0d.bin", i), 32'(bin_out), 32'd8);
      check($sformatf("frz%0d.pulse", i), 32'({valid, step_err}), 32'd0);
    end
    repeat (LAT) @(negedge clk);
    check("frz.bin_end", 32'(bin_out), 32'd8);

    // reset mid-stream with en high: reset wins, then relock silently on 1010 (12)
    gray_in = 4'b0101; en = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    check("mrst.locked", 32'(locked), 32'd0);
    check("mrst.bin",    32'(bin_out), 32'd0);
    send(4'b1010);
    check("relock.locked", 32'(locked), 32'd1);
    expect_out("relock", 4'd12, 1'b0, 1'b1, 1'b0);
    check("relock.err", 32'(err_cnt), 32'd0);

    // latency: 12 -> 13 (gray 1011) not visible one edge early, visible on time
    gray_in = 4'b1011; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (LAT - 2) @(negedge clk);
    check("lat.early_bin",   32'(bin_out), 32'd12);
    check("lat.early_valid", 32'(valid),   32'd0);
    @(negedge clk);
    expect_out("lat.ontime", 4'd13, 1'b1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
